// File: rtl/ddr4_req_arbiter.sv
// Round-robin arbiter and command sequencer for the DDR4 controller port.
// Define ARB_TIMEOUT_EN to add the ISSUE/BUSY watchdog and rsp_err.
module ddr4_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_we,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*16-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [15:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic [ID_W-1:0]        gnt_id,
  output logic                   busy,
  input  logic                   ctl_ready,
  input  logic [15:0]            ctl_rdata,
  output logic                   ctl_read_en,
  output logic                   ctl_write_en,
  output logic [31:0]            ctl_addr,
  output logic [15:0]            ctl_wdata
);

  localparam int IW = ID_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY,
    RESP
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] gnt_q, rr_ptr, pick;
  logic [IW-1:0]   idx;
  logic            found, grant, to_resp, timeout, done_ok;
  logic            we_q, err_q;
  logic [31:0]     addr_q;
  logic [15:0]     wdata_q, rdata_q;

  // Search starts one past the last winner and wraps.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + IW'(k);
      if (idx >= IW'(NUM_REQ)) idx = idx - IW'(NUM_REQ);
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[ID_W-1:0];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state_q == IDLE) begin
      wd_cnt <= '0;
    end else if (state_q == ISSUE || state_q == BUSY) begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end

  assign timeout = (state_q == ISSUE || state_q == BUSY) &&
                   (wd_cnt == 16'(TIMEOUT_CYC - 1));
`else
  logic unused_to;
  assign unused_to = ^32'(TIMEOUT_CYC);
  assign timeout   = 1'b0;
`endif

  assign grant   = (state_q == IDLE) && found && ctl_ready;
  assign done_ok = (state_q == BUSY) && ctl_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (grant) state_d = ISSUE;
      ISSUE: begin
        if (timeout)         state_d = RESP;
        else if (!ctl_ready) state_d = BUSY;
      end
      BUSY:  if (ctl_ready || timeout) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign to_resp = (state_d == RESP) && (state_q != RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      rr_ptr  <= ID_W'(NUM_REQ - 1);
    end else begin
      if (grant) begin
        gnt_q   <= pick;
        we_q    <= req_we[pick];
        addr_q  <= req_addr[{pick, 5'b0} +: 32];
        wdata_q <= req_wdata[{pick, 4'b0} +: 16];
      end
      if (done_ok && !we_q) rdata_q <= ctl_rdata;
      if (to_resp)          err_q   <= timeout && !done_ok;
      if (state_q == RESP)  rr_ptr  <= gnt_q;
    end
  end

  assign req_ack      = (state_q == RESP) ? (NUM_REQ'(1) << gnt_q) : '0;
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = err_q;
  assign gnt_id       = gnt_q;
  assign busy         = (state_q != IDLE);
  assign ctl_read_en  = (state_q == ISSUE) && !we_q;
  assign ctl_write_en = (state_q == ISSUE) && we_q;
  assign ctl_addr     = addr_q;
  assign ctl_wdata    = wdata_q;

endmodule

// File: tb/tb_ddr4_req_arbiter.sv
// Bench for ddr4_req_arbiter: controller model plus transaction-level
// round-robin reference, randomized requests.
module tb_ddr4_req_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_we = '0;
  logic [N*32-1:0] req_addr = '0;
  logic [N*16-1:0] req_wdata = '0;
  logic [N-1:0]  req_ack;
  logic [15:0]   rsp_rdata;
  logic          rsp_err;
  logic [1:0]    gnt_id;
  logic          busy;
  logic          ctl_ready;
  logic [15:0]   ctl_rdata;
  logic          ctl_read_en;
  logic          ctl_write_en;
  logic [31:0]   ctl_addr;
  logic [15:0]   ctl_wdata;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [15:0] last_rdata = '0;

  // Controller model: IDLE -> ACTIVATE -> READ/WRITE -> PRECHARGE -> IDLE
  typedef enum logic [1:0] {C_IDLE, C_ACT, C_RW, C_PRE} cst_t;
  cst_t        cst;
  logic        hold_off = 1'b0;
  logic        stuck = 1'b0;
  logic        force_en = 1'b0;
  logic [15:0] force_val = '0;
  logic [31:0] cmd_addr;

  assign ctl_ready = (cst == C_IDLE) && !hold_off;
  assign ctl_rdata = force_en ? force_val : (cmd_addr[15:0] ^ 16'h5A5A);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cst      <= C_IDLE;
      cmd_addr <= '0;
    end else begin
      case (cst)
        C_IDLE: if (ctl_ready && !stuck && (ctl_read_en || ctl_write_en)) begin
          cst      <= C_ACT;
          cmd_addr <= ctl_addr;
        end
        C_ACT: cst <= C_RW;
        C_RW:  cst <= C_PRE;
        C_PRE: cst <= C_IDLE;
        default: cst <= C_IDLE;
      endcase
    end
  end

  ddr4_req_arbiter #(
    .NUM_REQ(N),
    .ID_W(2),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_ack(req_ack),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .gnt_id(gnt_id),
    .busy(busy),
    .ctl_ready(ctl_ready),
    .ctl_rdata(ctl_rdata),
    .ctl_read_en(ctl_read_en),
    .ctl_write_en(ctl_write_en),
    .ctl_addr(ctl_addr),
    .ctl_wdata(ctl_wdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if (!$onehot0(req_ack)) begin
        bad++;
        $display("FAIL ack_onehot got=%b required at most one bit", req_ack);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    req_we = '0;
    hold_off = 1'b0;
    stuck = 1'b0;
    force_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_rdata = '0;
  endtask

  task automatic new_payload(input int i);
    req_we[i] = 1'($urandom_range(0, 1));
    req_addr[32*i +: 32] = $urandom;
    req_wdata[32'(16*i) +: 16] = 16'($urandom);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '1;
    req_we = '1;
    repeat (3) @(negedge clk);
    total++;
    if (req_ack !== '0) begin
      bad++; $display("FAIL reset_ack got=%b required=0", req_ack);
    end
    total++;
    if (rsp_rdata !== '0 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL reset_rsp got=%h/%b required=0/0", rsp_rdata, rsp_err);
    end
    total++;
    if ({busy, gnt_id, ctl_read_en, ctl_write_en} !== '0) begin
      bad++;
      $display("FAIL reset_ctl got busy=%b gnt=%0d rd=%b wr=%b required all 0",
               busy, gnt_id, ctl_read_en, ctl_write_en);
    end
    total++;
    if (ctl_addr !== '0 || ctl_wdata !== '0) begin
      bad++; $display("FAIL reset_bus got=%h/%h required=0/0", ctl_addr, ctl_wdata);
    end
    req_valid = '0;
    req_we = '0;
  endtask

  task automatic test_single_read();
    logic [8:0] rd_mask;
    logic [3:0] ackv;
    int ack_at;
    apply_reset();
    force_en = 1'b1;
    force_val = 16'hBEEF;
    req_we = '0;
    req_addr[64 +: 32] = 32'h0001_0008;
    req_valid = 4'b0100;
    rd_mask = '0;
    ackv = '0;
    ack_at = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      rd_mask[k] = ctl_read_en;
      if (k == 1) begin
        total++;
        if (ctl_addr !== 32'h0001_0008 || gnt_id !== 2'd2) begin
          bad++;
          $display("FAIL rd_addr got=%h gnt=%0d required=00010008 gnt=2", ctl_addr, gnt_id);
        end
      end
      if (req_ack != '0 && ack_at < 0) begin
        ack_at = k;
        ackv = req_ack;
        total++;
        if (rsp_rdata !== 16'hBEEF) begin
          bad++; $display("FAIL rd_data got=%h required=beef", rsp_rdata);
        end
        req_valid = '0;
      end
    end
    total++;
    if (rd_mask !== 9'b0_0000_0110) begin
      bad++; $display("FAIL rd_enable_cycles got=%b required=000000110", rd_mask);
    end
    total++;
    if (ack_at != 6 || ackv !== 4'b0100) begin
      bad++; $display("FAIL rd_ack got cycle=%0d val=%b required cycle=6 val=0100", ack_at, ackv);
    end
    force_en = 1'b0;
    last_rdata = 16'hBEEF;
  endtask

  task automatic test_write();
    logic [8:0] wr_mask, rd_mask;
    logic [3:0] ackv;
    int ack_at;
    req_we = 4'b0010;
    req_addr[32 +: 32] = 32'h00A0_0040;
    req_wdata[16 +: 16] = 16'h1234;
    req_valid = 4'b0010;
    wr_mask = '0;
    rd_mask = '0;
    ackv = '0;
    ack_at = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      wr_mask[k] = ctl_write_en;
      rd_mask[k] = ctl_read_en;
      if (k == 3) begin
        total++;
        if (ctl_wdata !== 16'h1234 || ctl_addr !== 32'h00A0_0040) begin
          bad++; $display("FAIL wr_bus got=%h/%h required=1234/00a00040", ctl_wdata, ctl_addr);
        end
      end
      if (req_ack != '0 && ack_at < 0) begin
        ack_at = k;
        ackv = req_ack;
        total++;
        if (rsp_rdata !== last_rdata) begin
          bad++; $display("FAIL wr_rdata_kept got=%h required=%h", rsp_rdata, last_rdata);
        end
        req_valid = '0;
      end
    end
    total++;
    if (wr_mask !== 9'b0_0000_0110 || rd_mask !== '0) begin
      bad++; $display("FAIL wr_enable_cycles got wr=%b rd=%b required wr=000000110 rd=0", wr_mask, rd_mask);
    end
    total++;
    if (ack_at != 6 || ackv !== 4'b0010) begin
      bad++; $display("FAIL wr_ack got cycle=%0d val=%b required cycle=6 val=0010", ack_at, ackv);
    end
    req_we = '0;
  endtask

  task automatic test_ready_low();
    logic ok;
    int start, got;
    hold_off = 1'b1;
    req_we = '0;
    req_addr[96 +: 32] = 32'h0000_7777;
    req_valid = 4'b1000;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0 || ctl_read_en !== 1'b0 || ctl_write_en !== 1'b0) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++; $display("FAIL ready_low_idle got activity while ctl_ready=0, required none");
    end
    hold_off = 1'b0;
    start = cyc;
    got = 0;
    for (int b = 0; b < 12 && got == 0; b++) begin
      @(negedge clk);
      if (req_ack != '0) got = 1;
    end
    total++;
    if (got == 0 || req_ack !== 4'b1000 || cyc - start != 6) begin
      bad++;
      $display("FAIL ready_low_ack got=%b after %0d required=1000 after 6", req_ack, cyc - start);
    end
    last_rdata = 16'h7777 ^ 16'h5A5A;
    total++;
    if (rsp_rdata !== last_rdata) begin
      bad++; $display("FAIL ready_low_data got=%h required=%h", rsp_rdata, last_rdata);
    end
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    int last, expw, ackc, prevc, got, gap;
    int wc[N];
    apply_reset();
    for (int i = 0; i < N; i++) begin
      new_payload(i);
      wc[i] = 0;
    end
    req_valid = '1;
    last = N - 1;
    prevc = cyc;
    for (int t = 0; t < 24; t++) begin
      got = 0;
      for (int b = 0; b < 12 && got == 0; b++) begin
        @(negedge clk);
        if (req_ack != '0) got = 1;
      end
      total++;
      if (got == 0) begin
        bad++; $display("FAIL rr_ack_timeout t=%0d got no ack, required one within 12 cycles", t);
        break;
      end
      expw = -1;
      for (int k = 1; k <= N && expw < 0; k++)
        if (req_valid[(last + k) % N]) expw = (last + k) % N;
      ackc = cyc;
      total++;
      if (req_ack !== 4'(1 << expw)) begin
        bad++; $display("FAIL rr_order t=%0d got=%b required=%b", t, req_ack, 4'(1 << expw));
      end
      gap = (t == 0) ? 6 : 7;
      total++;
      if (ackc - prevc != gap) begin
        bad++; $display("FAIL rr_gap t=%0d got=%0d required=%0d", t, ackc - prevc, gap);
      end
      total++;
      if (wc[expw] > N - 1) begin
        bad++; $display("FAIL rr_fair t=%0d req=%0d waited=%0d required<=%0d", t, expw, wc[expw], N - 1);
      end
      total++;
      if (ctl_addr !== req_addr[32*expw +: 32]) begin
        bad++; $display("FAIL rr_addr t=%0d got=%h required=%h", t, ctl_addr, req_addr[32*expw +: 32]);
      end
      if (req_we[expw]) begin
        total++;
        if (ctl_wdata !== req_wdata[32'(16*expw) +: 16]) begin
          bad++;
          $display("FAIL rr_wdata t=%0d got=%h required=%h", t, ctl_wdata, req_wdata[32'(16*expw) +: 16]);
        end
      end else begin
        last_rdata = req_addr[32*expw +: 16] ^ 16'h5A5A;
      end
      total++;
      if (rsp_rdata !== last_rdata) begin
        bad++; $display("FAIL rr_rdata t=%0d got=%h required=%h", t, rsp_rdata, last_rdata);
      end
      prevc = ackc;
      last = expw;
      for (int i = 0; i < N; i++)
        if (i != expw && req_valid[i]) wc[i]++;
      req_valid[expw] = 1'b0;
      if (t < 4 || $urandom_range(0, 1) == 1) begin
        new_payload(expw);
        req_valid[expw] = 1'b1;
        wc[expw] = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (i != expw && !req_valid[i] && $urandom_range(0, 2) == 0) begin
          new_payload(i);
          req_valid[i] = 1'b1;
          wc[i] = 0;
        end
      end
      if (req_valid == '0) begin
        new_payload(0);
        req_valid[0] = 1'b1;
        wc[0] = 0;
      end
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int ackseen, got, start;
    apply_reset();
    req_we = '0;
    req_addr[32 +: 32] = 32'h0000_4321;
    req_valid = 4'b0010;
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL mid_busy got=%b required=1", busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({req_ack, busy, ctl_read_en, ctl_write_en, gnt_id, rsp_err} !== '0 ||
        rsp_rdata !== '0 || ctl_addr !== '0 || ctl_wdata !== '0) begin
      bad++;
      $display("FAIL mid_async got ack=%b busy=%b gnt=%0d addr=%h required all 0",
               req_ack, busy, gnt_id, ctl_addr);
    end
    req_addr[0 +: 32] = 32'h0000_0A0A;
    req_valid = 4'b0011;
    ackseen = 0;
    repeat (2) begin
      @(negedge clk);
      if (req_ack != '0) ackseen = 1;
    end
    rst_n = 1'b1;
    last_rdata = '0;
    start = cyc;
    got = 0;
    for (int b = 0; b < 12 && got == 0; b++) begin
      @(negedge clk);
      if (req_ack != '0) got = 1;
    end
    total++;
    if (ackseen != 0) begin
      bad++; $display("FAIL mid_no_ack got an ack during reset, required none");
    end
    total++;
    if (got == 0 || req_ack !== 4'b0001 || cyc - start != 6) begin
      bad++;
      $display("FAIL mid_regrant got=%b after %0d required=0001 after 6", req_ack, cyc - start);
    end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    int start, got;
`ifdef ARB_TIMEOUT_EN
    apply_reset();
    stuck = 1'b1;
    req_we = '0;
    req_addr[0 +: 32] = 32'h0000_1111;
    req_valid = 4'b0001;
    start = cyc;
    got = 0;
    for (int b = 0; b < 20 && got == 0; b++) begin
      @(negedge clk);
      if (req_ack != '0) got = 1;
    end
    total++;
    if (got == 0 || req_ack !== 4'b0001 || cyc - start != 9) begin
      bad++; $display("FAIL to_ack got=%b after %0d required=0001 after 9", req_ack, cyc - start);
    end
    total++;
    if (rsp_err !== 1'b1 || rsp_rdata !== last_rdata) begin
      bad++;
      $display("FAIL to_err got err=%b data=%h required err=1 data=%h", rsp_err, rsp_rdata, last_rdata);
    end
    stuck = 1'b0;
    req_addr[0 +: 32] = 32'h0000_2222;
    start = cyc;
    got = 0;
    for (int b = 0; b < 12 && got == 0; b++) begin
      @(negedge clk);
      if (req_ack != '0) got = 1;
    end
    total++;
    if (got == 0 || cyc - start != 7 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL to_recover got err=%b after %0d required err=0 after 7", rsp_err, cyc - start);
    end
    total++;
    if (rsp_rdata !== (16'h2222 ^ 16'h5A5A)) begin
      bad++; $display("FAIL to_rdata got=%h required=%h", rsp_rdata, 16'h2222 ^ 16'h5A5A);
    end
    req_valid = '0;
`else
    logic ok;
    apply_reset();
    stuck = 1'b1;
    req_we = '0;
    req_valid = 4'b0001;
    start = cyc;
    got = 0;
    ok = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (req_ack != '0 || busy !== 1'b1 || rsp_err !== 1'b0) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++; $display("FAIL stuck_wait got ack or idle while stuck, required busy=1 and no ack");
    end
    stuck = 1'b0;
    apply_reset();
`endif
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_ready_low();
    test_round_robin();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
